// File: rtl/obi_data_arbiter_if.sv
// obi_data_arbiter_if: two-master / one-slave OBI data bus bundle around the arbiter
interface obi_data_arbiter_if #(parameter int ADDR_WIDTH = 32);
  logic                  m0_req_i;
  logic                  m0_gnt_o;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic                  m0_we_i;
  logic [3:0]            m0_be_i;
  logic [31:0]           m0_wdata_i;
  logic                  m0_rvalid_o;
  logic [31:0]           m0_rdata_o;
  logic                  m1_req_i;
  logic                  m1_gnt_o;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic                  m1_we_i;
  logic [3:0]            m1_be_i;
  logic [31:0]           m1_wdata_i;
  logic                  m1_rvalid_o;
  logic [31:0]           m1_rdata_o;
  logic                  s_req_o;
  logic                  s_gnt_i;
  logic [ADDR_WIDTH-1:0] s_addr_o;
  logic                  s_we_o;
  logic [3:0]            s_be_o;
  logic [31:0]           s_wdata_o;
  logic                  s_rvalid_i;
  logic [31:0]           s_rdata_i;
  modport slave (
    input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    input  s_gnt_i, s_rvalid_i, s_rdata_i
  );
  modport master (
    output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    output s_gnt_i, s_rvalid_i, s_rdata_i
  );
endinterface

// File: rtl/obi_data_arbiter.sv
// obi_data_arbiter: round-robin 2:1 OBI data arbiter with in-order response routing
module obi_data_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  obi_data_arbiter_if.slave                        bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                     err_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  logic [CW-1:0]              r_count;
  logic [PW-1:0]              r_rd;
  logic [PW-1:0]              r_wr;
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic                       r_last;
  logic                       r_locked;
  logic                       r_lock_sel;
  logic                       r_err;
  logic                       w_full;
  logic                       w_sel;
  logic                       w_req;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_head;
  logic [ADDR_WIDTH-1:0]      w_addr;
  // Pick a master: hold while a request waits for grant, else round-robin against the last granted
  always_comb begin
    w_full = r_count == CW'(MAX_OUTSTANDING);
    w_sel  = r_locked ? r_lock_sel : (bus.m0_req_i & bus.m1_req_i) ? ~r_last : bus.m1_req_i;
    w_req  = (w_sel ? bus.m1_req_i : bus.m0_req_i) & ~w_full;
    w_push = w_req & bus.s_gnt_i;
    w_pop  = bus.s_rvalid_i & (r_count != '0);
    w_head = r_fifo[r_rd];
    w_addr = w_sel ? bus.m1_addr_i : bus.m0_addr_i;
  end
  assign bus.s_req_o     = w_req;
  assign bus.s_addr_o    = w_addr;
  assign bus.s_we_o      = w_sel ? bus.m1_we_i : bus.m0_we_i;
  assign bus.s_be_o      = w_sel ? bus.m1_be_i : bus.m0_be_i;
  assign bus.s_wdata_o   = w_sel ? bus.m1_wdata_i : bus.m0_wdata_i;
  assign bus.m0_gnt_o    = w_push & ~w_sel;
  assign bus.m1_gnt_o    = w_push & w_sel;
  assign bus.m0_rvalid_o = w_pop & ~w_head;
  assign bus.m1_rvalid_o = w_pop & w_head;
  assign bus.m0_rdata_o  = bus.s_rdata_i;
  assign bus.m1_rdata_o  = bus.s_rdata_i;
  assign outstanding_o   = r_count;
  assign err_o           = r_err;
  // Track issuing-master IDs in order, the round-robin pointer, the hold flag and the stray-response error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count    <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_fifo     <= '0;
      r_last     <= 1'b1;
      r_locked   <= 1'b0;
      r_lock_sel <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_locked   <= w_req & ~bus.s_gnt_i;
      r_lock_sel <= w_sel;
      if (w_push) begin
        r_fifo[r_wr] <= w_sel;
        r_wr         <= (r_wr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr + 1'b1;
        r_last       <= w_sel;
      end
      if (w_pop) r_rd <= (r_rd == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (bus.s_rvalid_i && r_count == '0) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_obi_data_arbiter.sv
// tb_obi_data_arbiter: directed and random traffic against a queue-based arbiter model
module tb_obi_data_arbiter;
  localparam int MAX = 4;
  localparam int AW  = 32;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] outstanding;
  logic       err;
  int         checks = 0;
  int         errors = 0;
  bit         q[$];
  bit         last;
  bit         hold;
  bit         hold_m;
  bit         merr;
  always #5 clk = ~clk;
  obi_data_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  obi_data_arbiter #(.MAX_OUTSTANDING(MAX), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .outstanding_o(outstanding), .err_o(err)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    last   = 1'b1;
    hold   = 1'b0;
    hold_m = 1'b0;
    merr   = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.m0_req_i   = 1'b0;
    bus.m1_req_i   = 1'b0;
    bus.s_gnt_i    = 1'b0;
    bus.s_rvalid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic cyc(input bit r0, input bit r1, input bit sg, input bit sv, input logic [31:0] rd);
    bit sel, req, pop, head;
    logic [31:0] a0, a1, w0, w1;
    logic [3:0]  b0, b1;
    bit          e0, e1;
    a0 = $urandom; a1 = $urandom; w0 = $urandom; w1 = $urandom;
    b0 = 4'($urandom); b1 = 4'($urandom); e0 = 1'($urandom); e1 = 1'($urandom);
    @(negedge clk);
    bus.m0_req_i = r0; bus.m0_addr_i = a0; bus.m0_we_i = e0; bus.m0_be_i = b0; bus.m0_wdata_i = w0;
    bus.m1_req_i = r1; bus.m1_addr_i = a1; bus.m1_we_i = e1; bus.m1_be_i = b1; bus.m1_wdata_i = w1;
    bus.s_gnt_i = sg; bus.s_rvalid_i = sv; bus.s_rdata_i = rd;
    #1;
    sel  = hold ? hold_m : (r0 && r1) ? !last : r1;
    req  = (sel ? r1 : r0) && q.size() < MAX;
    pop  = sv && q.size() > 0;
    head = (q.size() > 0) ? q[0] : 1'b0;
    check("outstanding", 32'(outstanding), 32'(q.size()));
    check("err", 32'(err), 32'(merr));
    check("s_req", 32'(bus.s_req_o), 32'(req));
    check("m0_gnt", 32'(bus.m0_gnt_o), 32'(req && sg && !sel));
    check("m1_gnt", 32'(bus.m1_gnt_o), 32'(req && sg && sel));
    check("m0_rvalid", 32'(bus.m0_rvalid_o), 32'(pop && !head));
    check("m1_rvalid", 32'(bus.m1_rvalid_o), 32'(pop && head));
    check("m0_rdata", bus.m0_rdata_o, rd);
    check("m1_rdata", bus.m1_rdata_o, rd);
    if (req) begin
      check("s_addr", bus.s_addr_o, sel ? a1 : a0);
      check("s_wdata", bus.s_wdata_o, sel ? w1 : w0);
      check("s_be_we", {27'b0, bus.s_be_o, bus.s_we_o}, sel ? {27'b0, b1, e1} : {27'b0, b0, e0});
    end
    @(posedge clk);
    if (sv && q.size() == 0) merr = 1'b1;
    if (pop) void'(q.pop_front());
    if (req && sg) begin
      q.push_back(sel);
      last = sel;
    end
    hold   = req && !sg;
    hold_m = sel;
  endtask
  task automatic drain();
    for (int i = 0; i < 2 * MAX && q.size() > 0; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, $urandom);
  endtask
  initial begin
    rst = 1'b1;
    bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0; bus.s_gnt_i = 1'b0; bus.s_rvalid_i = 1'b0;
    bus.s_rdata_i = '0;
    model_reset();
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, q.size() > 0, $urandom);
    drain();
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, $urandom);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, $urandom);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, $urandom);
    drain();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
    drain();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, $urandom);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, q.size() > 0, $urandom);
    drain();
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, $urandom);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, $urandom);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r0, r1, sv;
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 2) != 0);
      if (hold) begin
        if (hold_m) r1 = 1'b1;
        else r0 = 1'b1;
      end
      sv = (q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 60) == 0);
      cyc(r0, r1, 1'($urandom), sv, $urandom);
      if ($urandom_range(0, 400) == 0) do_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
